// File: rtl/rgu_rst_req_gen_if.sv
// rgu_rst_req_gen_if: request inputs and active-low RGU request outputs of rgu_rst_req_gen.
// Rev 1.0
`default_nettype none

interface rgu_rst_req_gen_if #(
   parameter int NUM_WDT = 4
);
   logic               ext_rst_n;
   logic               sw_rst_req;
   logic [NUM_WDT-1:0] wdt_timeout;
   logic               sb_wdt_timeout;
   logic               cause_clr;
   logic               sys_reset_n;
   logic [NUM_WDT-1:0] wdt_rst_n;
   logic               sb_wdt_rst_n;
   logic [2:0]         rst_cause;
   logic               busy;

   modport master (
      output ext_rst_n, sw_rst_req, wdt_timeout, sb_wdt_timeout, cause_clr,
      input  sys_reset_n, wdt_rst_n, sb_wdt_rst_n, rst_cause, busy
   );

   modport slave (
      input  ext_rst_n, sw_rst_req, wdt_timeout, sb_wdt_timeout, cause_clr,
      output sys_reset_n, wdt_rst_n, sb_wdt_rst_n, rst_cause, busy
   );
endinterface

`default_nettype wire

// File: rtl/rgu_rst_req_gen.sv
// rgu_rst_req_gen: stretches reset requests to a minimum width and keeps a sticky cause record.
// Rev 1.0
`default_nettype none

module rgu_rst_req_gen #(
   parameter int NUM_WDT     = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int COOL_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 sys_pwrgd,
   rgu_rst_req_gen_if.slave     bus
);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] COOL_LOAD = 8'(COOL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      COOL   = 2'd2
   } state_t;

   logic         ext_meta;
   logic         ext_s;
   state_t       state;
   logic [7:0]   sys_cnt;
   logic         sys_req_n;
   logic         busy_q;
   logic [2:0]   cause_set;
   logic [2:0]   cause_q;
   logic [NUM_WDT:0] trig;
   logic [NUM_WDT:0] str_n;

   always_ff @(posedge clk) begin
      if (!sys_pwrgd) begin
         ext_meta <= 1'b1;
         ext_s    <= 1'b1;
      end else begin
         ext_meta <= bus.ext_rst_n;
         ext_s    <= ext_meta;
      end
   end

   // A held button keeps the hold counter reloaded, so release is HOLD_CYCLES after ext_s rises.
   always_ff @(posedge clk) begin
      if (!sys_pwrgd) begin
         state     <= IDLE;
         sys_cnt   <= 8'd0;
         sys_req_n <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!ext_s || bus.sw_rst_req) begin
                  state     <= ASSERT;
                  sys_cnt   <= HOLD_LOAD;
                  sys_req_n <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            ASSERT: begin
               if (!ext_s) begin
                  sys_cnt <= HOLD_LOAD;
               end else if (sys_cnt == 8'd0) begin
                  state     <= COOL;
                  sys_cnt   <= COOL_LOAD;
                  sys_req_n <= 1'b1;
               end else begin
                  sys_cnt <= sys_cnt - 8'd1;
               end
            end
            COOL: begin
               if (sys_cnt == 8'd0) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  sys_cnt <= sys_cnt - 8'd1;
               end
            end
            default: begin
               state     <= IDLE;
               sys_cnt   <= 8'd0;
               sys_req_n <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      cause_set    = 3'b000;
      cause_set[0] = (state == IDLE) && !ext_s;
      cause_set[1] = bus.sw_rst_req && (state != COOL);
      cause_set[2] = bus.sb_wdt_timeout;
   end

   // New causes override a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!sys_pwrgd) begin
         cause_q <= 3'b000;
      end else begin
         cause_q <= (bus.cause_clr ? 3'b000 : cause_q) | cause_set;
      end
   end

   assign trig = {bus.sb_wdt_timeout, bus.wdt_timeout};

   generate
      for (genvar i = 0; i <= NUM_WDT; i++) begin : g_stretch
         logic [7:0] cnt;
         logic       out_n;

         always_ff @(posedge clk) begin
            if (!sys_pwrgd) begin
               cnt   <= 8'd0;
               out_n <= 1'b1;
            end else if (trig[i]) begin
               cnt   <= HOLD_LOAD;
               out_n <= 1'b0;
            end else if (!out_n) begin
               if (cnt == 8'd0) begin
                  out_n <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
         end

         assign str_n[i] = out_n;
      end
   endgenerate

   assign bus.sys_reset_n  = sys_req_n;
   assign bus.wdt_rst_n    = str_n[NUM_WDT-1:0];
   assign bus.sb_wdt_rst_n = str_n[NUM_WDT];
   assign bus.rst_cause    = cause_q;
   assign bus.busy         = busy_q;

endmodule

`default_nettype wire

// File: doc/rgu_rst_req_gen.md
Name: rgu_rst_req_gen

Overview:
- Source side of the reset-generation-unit request interface.
- Collects reset requests from an external button, a software register pulse, the system watchdogs and the sideband watchdog.
- Stretches each request to a guaranteed minimum width and drives the active-low request lines the RGU consumes: sys_reset_n, wdt_rst_n, sb_wdt_rst_n.
- Clocked and reset by the always-on domain (clk / sys_pwrgd), so it survives every reset it requests; also keeps a sticky reset-cause record.

Parameters:
- NUM_WDT, 4, number of system watchdog request channels (width of wdt_timeout / wdt_rst_n).
- HOLD_CYCLES, 16, minimum low width of every request output, in clk cycles (legal range 2..255).
- COOL_CYCLES, 8, sys_reset_n lockout after release, during which new sw requests are dropped (legal range 1..255).

Ports:
- clk  in  1  always-on clock.
- sys_pwrgd  in  1  synchronous active-low reset (low = reset).
- ext_rst_n  in  1  asynchronous external reset button, active-low.
- sw_rst_req  in  1  single-cycle software system-reset request.
- wdt_timeout  in  NUM_WDT  per-watchdog timeout pulses.
- sb_wdt_timeout  in  1  sideband watchdog timeout pulse.
- cause_clr  in  1  single-cycle clear of rst_cause.
- sys_reset_n  out  1  system reset request to RGU, active-low.
- wdt_rst_n  out  NUM_WDT  per-watchdog reset requests to RGU, active-low.
- sb_wdt_rst_n  out  1  sideband watchdog reset request to RGU, active-low.
- rst_cause  out  3  sticky cause: bit0 ext, bit1 sw, bit2 sb_wdt.
- busy  out  1  high while the sys FSM is not IDLE.

Behaviour:
- Reset (sys_pwrgd low at a clk edge): sys_reset_n=1, wdt_rst_n=all 1, sb_wdt_rst_n=1, rst_cause=0, busy=0, FSM=IDLE, all counters=0, both ext synchronizer flops=1.
- Reset is honoured mid-operation: any stretch in progress is abandoned and outputs return high on the next edge.
- All outputs are registered.
- ext_rst_n passes through a 2-flop synchronizer; ext_s is the synchronized value.

Sys FSM:
- States: IDLE, ASSERT, COOL.
- IDLE -> ASSERT when ext_s==0 or sw_rst_req==1.
  - Load cnt=HOLD_CYCLES-1.
  - sys_reset_n goes low on the same edge, i.e. 1 cycle after sw_rst_req is sampled.
- ASSERT:
  - While ext_s==0, cnt is held at HOLD_CYCLES-1.
  - Otherwise cnt decrements.
  - At cnt==0 with ext_s==1 -> COOL, load cnt=COOL_CYCLES-1, sys_reset_n=1.
  - A sw-only request therefore gives exactly HOLD_CYCLES low cycles.
  - An ext request gives its synchronized low duration + HOLD_CYCLES.
- COOL:
  - cnt decrements; sw_rst_req is dropped (no record, no cause).
  - At cnt==0 -> IDLE.
  - If ext_s is still 0 on entry to IDLE, re-trigger on the next cycle.
- sw_rst_req in ASSERT: no effect on timing; cause is still recorded.

Watchdog stretchers (per bit i of wdt_timeout, plus one for sb_wdt_timeout):
- Each channel is independent of the FSM and of the other channels.
- A pulse in any cycle loads cnt_i=HOLD_CYCLES-1 and drives the output low on the next edge.
- The output stays low while cnt_i>0 and for the cycle cnt_i==0.
- A new pulse while active reloads cnt_i (retrigger extends the low period).
- Pulses in consecutive cycles extend; they never create a high glitch.

rst_cause:
- A bit sets when the corresponding request is accepted: ext on IDLE->ASSERT from ext_s, sw when FSM is not COOL, sb_wdt on any pulse.
- cause_clr clears all bits; a set in the same cycle as cause_clr wins.
- rst_cause is not cleared by the resets this block requests, only by sys_pwrgd.
- wdt_timeout has no cause bit.

Counters: 8 bits, never wrap (saturate at 0).

Test Plan:
1. sys_pwrgd low 3 cycles, then high with all inputs idle -> all request outputs 1, rst_cause=0, busy=0.
2. sw_rst_req pulse at cycle 10 -> sys_reset_n low cycles 11..26 (16 cycles), busy high 11..34, rst_cause=3'b010; a second sw_rst_req at cycle 30 (COOL) is ignored, no further low.
3. ext_rst_n low for 20 cycles from cycle 5 -> sys_reset_n falls at cycle 8 (sync + FSM) and stays low until 16 cycles after ext_s rises; rst_cause bit0 set; ext held low through COOL re-asserts immediately after COOL.
4. wdt_timeout=4'b0101 at cycle 4, then bit0 again at cycle 10 -> wdt_rst_n[2] low 5..20; wdt_rst_n[0] low 5..26; bits 1 and 3 stay 1; sys_reset_n unaffected.
5. sb_wdt_timeout and cause_clr in the same cycle with rst_cause=3'b011 -> rst_cause=3'b100, sb_wdt_rst_n low 16 cycles.
6. sys_pwrgd asserted low mid-ASSERT (cnt=7) -> next edge sys_reset_n=1, busy=0, rst_cause=0; after release a fresh sw_rst_req gives a full 16-cycle assertion.
